// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and config-word layout for the FFT frame sequencer.
// The FFT core expects this word on S_AXIS_CONFIG.
package fft_frame_ctrl_pkg;

    localparam int unsigned CfgW      = 24;
    localparam int unsigned SampleW   = 32;
    localparam int unsigned NfftW     = 5;
    localparam int unsigned CpW       = 7;
    localparam int unsigned NfftLsb   = 0;
    localparam int unsigned CpLsb     = 8;
    localparam int unsigned FwdBit    = 16;
    localparam int unsigned ErrW      = 3;
    localparam int unsigned FrameCntW = 16;

    typedef enum logic {
        StConfig = 1'b0,
        StStream = 1'b1
    } state_e;

    typedef struct packed {
        logic [NfftW-1:0] nfft_log2;
        logic             fwd_inv;
        logic [CpW-1:0]   cp_len;
    } fft_cfg_t;

    function automatic logic [CfgW-1:0] pack_cfg(input fft_cfg_t c);
        logic [CfgW-1:0] w;
        w                       = '0;
        w[NfftLsb +: NfftW]     = c.nfft_log2;
        w[CpLsb +: CpW]         = c.cp_len;
        w[FwdBit]               = c.fwd_inv;
        return w;
    endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Upstream sample stream plus all FFT-core-facing handshakes of the sequencer.
// master = sequencer side, slave = upstream source / FFT core side.
interface fft_frame_ctrl_if;

    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;

    logic [23:0] fft_cfg_tdata;
    logic        fft_cfg_tvalid;
    logic        fft_cfg_tready;

    logic [31:0] fft_din_tdata;
    logic        fft_din_tvalid;
    logic        fft_din_tlast;
    logic        fft_din_tready;

    logic        fft_dout_tvalid;
    logic        fft_dout_tready;
    logic        fft_dout_tlast;

    logic        ev_tlast_missing;
    logic        ev_tlast_unexp;

    modport master (
        input  s_tdata, s_tvalid,
        output s_tready,
        output fft_cfg_tdata, fft_cfg_tvalid,
        input  fft_cfg_tready,
        output fft_din_tdata, fft_din_tvalid, fft_din_tlast,
        input  fft_din_tready,
        input  fft_dout_tvalid, fft_dout_tready, fft_dout_tlast,
        input  ev_tlast_missing, ev_tlast_unexp
    );

    modport slave (
        output s_tdata, s_tvalid,
        input  s_tready,
        input  fft_cfg_tdata, fft_cfg_tvalid,
        output fft_cfg_tready,
        input  fft_din_tdata, fft_din_tvalid, fft_din_tlast,
        output fft_din_tready,
        output fft_dout_tvalid, fft_dout_tready, fft_dout_tlast,
        output ev_tlast_missing, ev_tlast_unexp
    );

endinterface

// File: rtl/fft_frame_ctrl_counter.sv
// Per-frame sample counter; flags the final beat of a 2^nfft_log2 frame.
module fft_frame_ctrl_counter
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned MAX_NFFT_LOG2 = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NfftW-1:0] nfft_log2,
    input  logic             beat,
    output logic             last
);

    localparam int unsigned CntW = MAX_NFFT_LOG2;

    logic [CntW-1:0] cnt_q, cnt_d, len_m1;

    always_comb begin
        len_m1 = CntW'((32'd1 << nfft_log2) - 32'd1);
        last   = (cnt_q == len_m1);
        cnt_d  = cnt_q;
        if (beat) begin
            cnt_d = last ? '0 : cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fft_frame_ctrl.sv
// Sequencer in front of the FFT core: issues config words at frame boundaries,
// frames upstream samples with tlast, bounds frames in flight and tracks errors.
module fft_frame_ctrl
    import fft_frame_ctrl_pkg::*;
#(
    parameter int unsigned MAX_NFFT_LOG2 = 10,
    parameter int unsigned DEF_NFFT_LOG2 = 10,
    parameter int unsigned DEF_FWD_INV   = 1,
    parameter int unsigned MAX_INFLIGHT  = 2
) (
    input  logic                 aclk,
    input  logic                 areset,
    input  logic [NfftW-1:0]     cfg_nfft_log2,
    input  logic                 cfg_fwd_inv,
    input  logic [CpW-1:0]       cfg_cp_len,
    input  logic                 cfg_update,
    fft_frame_ctrl_if.master     bus,
    input  logic                 err_clear,
    output logic [ErrW-1:0]      err_sticky,
    output logic [FrameCntW-1:0] frames_in,
    output logic [FrameCntW-1:0] frames_out,
    output logic                 busy
);

    localparam int unsigned InflW = $clog2(MAX_INFLIGHT + 1);
    localparam logic [InflW-1:0] MaxInfl = InflW'(MAX_INFLIGHT);
    localparam fft_cfg_t DefCfg = '{
        nfft_log2: NfftW'(DEF_NFFT_LOG2),
        fwd_inv:   1'(DEF_FWD_INV),
        cp_len:    '0
    };

    state_e               state_q, state_d;
    fft_cfg_t             active_q, active_d;
    fft_cfg_t             pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [InflW-1:0]     inflight_q, inflight_d;
    logic [FrameCntW-1:0] frames_in_q, frames_in_d;
    logic [FrameCntW-1:0] frames_out_q, frames_out_d;
    logic [ErrW-1:0]      err_q, err_d;
    logic                 cfg_tvalid_q, cfg_tvalid_d;
    logic [CfgW-1:0]      cfg_tdata_q, cfg_tdata_d;
    logic                 busy_q, busy_d;

    logic     in_stream, gate, beat, frame_last, last_beat;
    logic     cfg_ok, upd_ok, upd_bad, cfg_hs, boundary;
    logic     inc, dec, underflow;
    fft_cfg_t req;

    assign in_stream          = (state_q == StStream);
    assign gate               = (inflight_q < MaxInfl);
    assign bus.s_tready       = in_stream & bus.fft_din_tready & gate;
    assign bus.fft_din_tvalid = in_stream & bus.s_tvalid & gate;
    assign bus.fft_din_tdata  = bus.s_tdata;
    assign bus.fft_din_tlast  = frame_last;
    assign beat               = bus.fft_din_tvalid & bus.fft_din_tready;
    assign last_beat          = beat & frame_last;

    fft_frame_ctrl_counter #(
        .MAX_NFFT_LOG2 (MAX_NFFT_LOG2)
    ) u_counter (
        .clk       (aclk),
        .rst       (areset),
        .nfft_log2 (active_q.nfft_log2),
        .beat      (beat),
        .last      (frame_last)
    );

    always_comb begin
        cfg_ok   = (cfg_nfft_log2 >= NfftW'(3)) && (cfg_nfft_log2 <= NfftW'(MAX_NFFT_LOG2));
        upd_ok   = cfg_update & cfg_ok;
        upd_bad  = cfg_update & ~cfg_ok;
        req      = '{nfft_log2: cfg_nfft_log2, fwd_inv: cfg_fwd_inv, cp_len: cfg_cp_len};
        cfg_hs   = ~in_stream & cfg_tvalid_q & bus.fft_cfg_tready;
        boundary = in_stream ? last_beat : cfg_hs;
    end

    // An update arriving on the boundary cycle itself is applied at that boundary.
    always_comb begin
        state_d      = state_q;
        active_d     = active_q;
        pend_d       = pend_q;
        pend_valid_d = pend_valid_q;
        if (upd_ok) begin
            pend_d       = req;
            pend_valid_d = 1'b1;
        end
        if (boundary) begin
            if (upd_ok || pend_valid_q) begin
                active_d     = upd_ok ? req : pend_q;
                pend_valid_d = 1'b0;
                state_d      = StConfig;
            end else begin
                state_d      = StStream;
            end
        end
    end

    always_comb begin
        inc          = last_beat;
        dec          = bus.fft_dout_tvalid & bus.fft_dout_tready & bus.fft_dout_tlast;
        underflow    = dec & ~inc & (inflight_q == '0);
        inflight_d   = inflight_q;
        unique case ({inc, dec})
            2'b10:   inflight_d = inflight_q + InflW'(1);
            2'b01:   inflight_d = underflow ? inflight_q : inflight_q - InflW'(1);
            default: inflight_d = inflight_q;
        endcase
        frames_in_d  = frames_in_q + FrameCntW'(inc);
        frames_out_d = frames_out_q + FrameCntW'(dec);
        // Set beats clear when both land in the same cycle.
        err_d        = (err_clear ? '0 : err_q)
                     | {upd_bad, bus.ev_tlast_unexp | underflow, bus.ev_tlast_missing};
        cfg_tvalid_d = (state_d == StConfig);
        cfg_tdata_d  = pack_cfg(active_d);
        busy_d       = ~((state_d == StStream) && (inflight_d == '0));
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q      <= StConfig;
            active_q     <= DefCfg;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            inflight_q   <= '0;
            frames_in_q  <= '0;
            frames_out_q <= '0;
            err_q        <= '0;
            cfg_tvalid_q <= 1'b0;
            cfg_tdata_q  <= pack_cfg(DefCfg);
            busy_q       <= 1'b1;
        end else begin
            state_q      <= state_d;
            active_q     <= active_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            inflight_q   <= inflight_d;
            frames_in_q  <= frames_in_d;
            frames_out_q <= frames_out_d;
            err_q        <= err_d;
            cfg_tvalid_q <= cfg_tvalid_d;
            cfg_tdata_q  <= cfg_tdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.fft_cfg_tvalid = cfg_tvalid_q;
    assign bus.fft_cfg_tdata  = cfg_tdata_q;
    assign err_sticky         = err_q;
    assign frames_in          = frames_in_q;
    assign frames_out         = frames_out_q;
    assign busy               = busy_q;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed bench for fft_frame_ctrl: config sequencing, framing, flow limit and error flags.
module tb_fft_frame_ctrl;

    logic        aclk = 1'b0;
    logic        areset;
    logic [4:0]  cfg_nfft_log2;
    logic        cfg_fwd_inv;
    logic [6:0]  cfg_cp_len;
    logic        cfg_update;
    logic        err_clear;
    logic [2:0]  err_sticky;
    logic [15:0] frames_in;
    logic [15:0] frames_out;
    logic        busy;

    fft_frame_ctrl_if bus ();

    fft_frame_ctrl dut (
        .aclk          (aclk),
        .areset        (areset),
        .cfg_nfft_log2 (cfg_nfft_log2),
        .cfg_fwd_inv   (cfg_fwd_inv),
        .cfg_cp_len    (cfg_cp_len),
        .cfg_update    (cfg_update),
        .bus           (bus),
        .err_clear     (err_clear),
        .err_sticky    (err_sticky),
        .frames_in     (frames_in),
        .frames_out    (frames_out),
        .busy          (busy)
    );

    always #5 aclk = ~aclk;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] src   = 32'h0;
    int          r_beats, r_tlasts, r_last_pos, r_data_err, r_cycles;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic pulse_dout();
        bus.fft_dout_tvalid = 1'b1;
        bus.fft_dout_tready = 1'b1;
        bus.fft_dout_tlast  = 1'b1;
        tick();
        bus.fft_dout_tvalid = 1'b0;
        bus.fft_dout_tready = 1'b0;
        bus.fft_dout_tlast  = 1'b0;
    endtask

    // Streams src-numbered samples; handshakes are observed mid-cycle.
    task automatic run(input int stop_beats, input int max_cyc, input bit rnd, input bit drain);
        bit drain_pend;
        drain_pend = 1'b0;
        r_beats = 0; r_tlasts = 0; r_last_pos = -1; r_data_err = 0; r_cycles = 0;
        for (int c = 0; c < max_cyc && r_beats < stop_beats; c++) begin
            bus.s_tvalid        = 1'b1;
            bus.s_tdata         = src;
            bus.fft_din_tready  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.fft_dout_tvalid = drain_pend;
            bus.fft_dout_tready = drain_pend;
            bus.fft_dout_tlast  = drain_pend;
            drain_pend          = 1'b0;
            #4;
            r_cycles++;
            if (bus.fft_din_tvalid && bus.fft_din_tready) begin
                if (bus.fft_din_tdata !== src) r_data_err++;
                if (bus.fft_din_tlast) begin
                    r_tlasts++;
                    r_last_pos = r_beats;
                    if (drain) drain_pend = 1'b1;
                end
                r_beats++;
                src++;
            end
            tick();
        end
        bus.s_tvalid        = 1'b0;
        bus.fft_din_tready  = 1'b1;
        bus.fft_dout_tvalid = 1'b0;
        bus.fft_dout_tready = 1'b0;
        bus.fft_dout_tlast  = 1'b0;
        if (drain_pend) pulse_dout();
    endtask

    initial begin
        areset = 1'b1;
        cfg_nfft_log2 = 5'd0; cfg_fwd_inv = 1'b0; cfg_cp_len = 7'd0; cfg_update = 1'b0;
        err_clear = 1'b0;
        bus.s_tdata = '0; bus.s_tvalid = 1'b0;
        bus.fft_cfg_tready = 1'b0; bus.fft_din_tready = 1'b1;
        bus.fft_dout_tvalid = 1'b0; bus.fft_dout_tready = 1'b0; bus.fft_dout_tlast = 1'b0;
        bus.ev_tlast_missing = 1'b0; bus.ev_tlast_unexp = 1'b0;

        // Reset state
        tick(); tick();
        chk("rst_cfg_tvalid", 32'(bus.fft_cfg_tvalid), 32'd0);
        chk("rst_cfg_tdata", 32'(bus.fft_cfg_tdata), 32'h01000A);
        chk("rst_s_tready", 32'(bus.s_tready), 32'd0);
        chk("rst_frames_in", 32'(frames_in), 32'd0);
        chk("rst_err", 32'(err_sticky), 32'd0);
        chk("rst_busy", 32'(busy), 32'd1);
        areset = 1'b0;

        // Config held for 5 cycles, handshake on the 6th
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("cfg_hold_tvalid", 32'(bus.fft_cfg_tvalid), 32'd1);
            chk("cfg_hold_tdata", 32'(bus.fft_cfg_tdata), 32'h01000A);
            chk("cfg_hold_s_tready", 32'(bus.s_tready), 32'd0);
        end
        bus.fft_cfg_tready = 1'b1;
        tick();
        bus.fft_cfg_tready = 1'b0;
        chk("stream_s_tready", 32'(bus.s_tready), 32'd1);
        chk("stream_cfg_tvalid", 32'(bus.fft_cfg_tvalid), 32'd0);
        chk("stream_busy", 32'(busy), 32'd0);

        // Frame 1: 1024 beats, no bubbles
        run(1024, 1100, 1'b0, 1'b0);
        chk("f1_cycles", 32'(r_cycles), 32'd1024);
        chk("f1_tlasts", 32'(r_tlasts), 32'd1);
        chk("f1_last_pos", 32'(r_last_pos), 32'd1023);
        chk("f1_data", 32'(r_data_err), 32'd0);
        chk("f1_frames_in", 32'(frames_in), 32'd1);
        chk("f1_busy", 32'(busy), 32'd1);

        // Frame 2 fills the in-flight budget; stream stalls after 2048 beats total
        run(4096, 1100, 1'b0, 1'b0);
        chk("f2_beats", 32'(r_beats), 32'd1024);
        chk("f2_tlasts", 32'(r_tlasts), 32'd1);
        chk("f2_frames_in", 32'(frames_in), 32'd2);
        chk("f2_stalled", 32'(bus.s_tready), 32'd0);
        pulse_dout();
        chk("dout_release", 32'(bus.s_tready), 32'd1);
        chk("dout_frames_out", 32'(frames_out), 32'd1);

        // Three frames with random din_tready, drained as they complete
        run(3072, 9000, 1'b1, 1'b1);
        chk("rnd_beats", 32'(r_beats), 32'd3072);
        chk("rnd_tlasts", 32'(r_tlasts), 32'd3);
        chk("rnd_last_pos", 32'(r_last_pos), 32'd3071);
        chk("rnd_data", 32'(r_data_err), 32'd0);
        chk("rnd_frames_in", 32'(frames_in), 32'd5);
        chk("rnd_frames_out", 32'(frames_out), 32'd4);

        // Mid-frame update: current frame keeps 1024, then nfft=6 inverse
        run(500, 600, 1'b0, 1'b0);
        cfg_nfft_log2 = 5'd6; cfg_fwd_inv = 1'b0; cfg_cp_len = 7'd0; cfg_update = 1'b1;
        run(1, 2, 1'b0, 1'b0);
        cfg_update = 1'b0;
        run(523, 600, 1'b0, 1'b0);
        chk("upd_tlasts", 32'(r_tlasts), 32'd1);
        chk("upd_last_pos", 32'(r_last_pos), 32'd522);
        chk("upd_frames_in", 32'(frames_in), 32'd6);
        chk("upd_cfg_tvalid", 32'(bus.fft_cfg_tvalid), 32'd1);
        chk("upd_cfg_tdata", 32'(bus.fft_cfg_tdata), 32'h000006);
        chk("upd_s_tready", 32'(bus.s_tready), 32'd0);
        pulse_dout();
        pulse_dout();
        chk("upd_cfg_stable", 32'(bus.fft_cfg_tdata), 32'h000006);
        chk("upd_frames_out", 32'(frames_out), 32'd6);
        bus.fft_cfg_tready = 1'b1;
        tick();
        bus.fft_cfg_tready = 1'b0;
        chk("upd_cfg_done", 32'(bus.fft_cfg_tvalid), 32'd0);
        chk("upd_idle_busy", 32'(busy), 32'd0);
        run(64, 100, 1'b0, 1'b0);
        chk("f64_last_pos", 32'(r_last_pos), 32'd63);
        chk("f64_tlasts", 32'(r_tlasts), 32'd1);
        chk("f64_frames_in", 32'(frames_in), 32'd7);

        // Error flags: set beats clear, clear alone, missing, underflow
        bus.ev_tlast_unexp = 1'b1; err_clear = 1'b1;
        tick();
        bus.ev_tlast_unexp = 1'b0;
        chk("err_set_wins", 32'(err_sticky), 32'b010);
        tick();
        err_clear = 1'b0;
        chk("err_cleared", 32'(err_sticky), 32'b000);
        bus.ev_tlast_missing = 1'b1;
        tick();
        bus.ev_tlast_missing = 1'b0;
        chk("err_missing", 32'(err_sticky), 32'b001);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        pulse_dout();
        chk("unf_first_ok", 32'(err_sticky), 32'b000);
        pulse_dout();
        chk("unf_err", 32'(err_sticky), 32'b010);
        chk("unf_frames_out", 32'(frames_out), 32'd8);
        chk("unf_busy", 32'(busy), 32'd0);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;

        // Out-of-range size request is dropped and flagged
        cfg_nfft_log2 = 5'd2; cfg_update = 1'b1;
        tick();
        cfg_update = 1'b0;
        chk("bad_cfg_err", 32'(err_sticky), 32'b100);
        run(64, 100, 1'b0, 1'b0);
        chk("bad_cfg_len", 32'(r_last_pos), 32'd63);
        chk("bad_cfg_no_config", 32'(bus.fft_cfg_tvalid), 32'd0);
        chk("bad_cfg_s_tready", 32'(bus.s_tready), 32'd1);

        // Reset mid-frame
        run(30, 40, 1'b0, 1'b0);
        areset = 1'b1;
        tick();
        chk("mrst_frames_in", 32'(frames_in), 32'd0);
        chk("mrst_frames_out", 32'(frames_out), 32'd0);
        chk("mrst_err", 32'(err_sticky), 32'd0);
        chk("mrst_s_tready", 32'(bus.s_tready), 32'd0);
        areset = 1'b0;
        tick();
        chk("mrst_cfg_tvalid", 32'(bus.fft_cfg_tvalid), 32'd1);
        chk("mrst_cfg_tdata", 32'(bus.fft_cfg_tdata), 32'h01000A);
        bus.fft_cfg_tready = 1'b1;
        tick();
        bus.fft_cfg_tready = 1'b0;
        run(1024, 1100, 1'b0, 1'b0);
        chk("mrst_last_pos", 32'(r_last_pos), 32'd1023);
        chk("mrst_frames_in2", 32'(frames_in), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
